cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
Parametrised, 2-stage pipelined carry-lookahead adder/subtractor for the x-bit ALU datapath.
- Generalises the per-bit sum/propagate/generate cell to WIDTH bits in GROUP-bit lookahead groups.
- Adds add/sub/carry modes, ALU flags and a valid/ready handshake with backpressure.
- Sits between the ALU operand mux and the result/flag writeback.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP, minimum 4.
GROUP, 4, bits per lookahead group; must be 2, 4 or 8.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid this cycle
in_ready  output  1  block accepts operands this cycle
op  input  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBC
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in; used by ADC/SBC only
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB; for SUB/SBC, 1 = no borrow
ovf  output  1  signed overflow
zero  output  1  sum == 0
neg  output  1  sum[WIDTH-1]

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0, neg=0. in_ready=1 during and after reset.
- Reset mid-operation discards all in-flight results. No output pulse after release.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en, combinational. Both stages advance only when en=1.
  - When stalled, every stage register holds.
  - A bubble in stage 1 is not filled while stalled.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput: 1 op/cycle.
- Operand prep, combinational before stage 1:
  - bx = b for ADD/ADC; bx = ~b for SUB/SBC.
  - c0 = 0 for ADD, 1 for SUB, cin for ADC/SBC.
- Stage 1 registers a, bx, c0 and per-bit p = a^bx, g = a&bx. It also registers group PG = AND of p over the group and group GG = lookahead generate of the group.
- Stage 2 computes:
  - group carries c[k+1] = GG[k] | PG[k]&c[k], starting from c[0] = c0;
  - in-group bit carries by lookahead from the group carry;
  - sum bit i = p[i] ^ carry[i].
  It registers sum and the flags.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero and neg are derived from the registered sum value.
- Arithmetic is modulo 2^WIDTH. No saturation.
- When out_valid=0, outputs hold their last values. Consumers must qualify with out_valid.
- Simultaneous out transfer and in transfer in the same cycle is legal and preserves full throughput.
- Order is strictly preserved. No drops or duplicates under any in_valid/out_ready pattern.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10, OP_SBC=2'b11;
  - the parameter-legality check constants.
- One sub-module, cla_group: GROUP-bit block with inputs p, g, carry-in and outputs sum, PG, GG. It is instantiated WIDTH/GROUP times in stage 2. Group PG/GG for stage 1 come from a shared function in alu_pkg.

Test Plan:
- rst_n=0 asserted mid-stream with 2 ops in flight, held 3 cycles, then released -> out_valid=0 and all outputs 0 during reset; no stale result appears after release; in_ready=1.
- ADD a=0x7FFF, b=0x0001 (WIDTH=16) -> 2 cycles later sum=0x8000, cout=0, ovf=1, neg=1, zero=0.
- SUB a=0x0005, b=0x0005 -> sum=0x0000, cout=1, zero=1, ovf=0. Then SUB a=0x0000, b=0x0001 -> sum=0xFFFF, cout=0, neg=1.
- ADC a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0. Then SBC a=0x0010, b=0x0001, cin=0 -> sum=0x000E.
- Backpressure: 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4), out_ready held 0 for 5 cycles from the first out_valid -> sum holds 0x0002 and in_ready=0 throughout. After release, results 2, 4, 6, 8 arrive in order, one per cycle.
- Parameter sweep WIDTH=8, GROUP=4 and WIDTH=32, GROUP=8 with 10k random ops and random in_valid/out_ready, checked against a reference model -> zero mismatches. Also 8-bit SUB 0x80 - 0x01 -> 0x7F with ovf=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the carry-lookahead adder/subtractor.
//   alu_op_e      : operation encodings driven on the op port
//   params_legal  : WIDTH/GROUP legality check used at elaboration
//   group_pg_gg   : group propagate/generate of one lookahead group
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBC = 2'b11
   } alu_op_e;

   localparam int MIN_WIDTH = 4;
   localparam int MAX_GROUP = 8;

   function automatic bit params_legal(input int width, input int group);
      return ((group == 2) || (group == 4) || (group == 8)) &&
             (width >= MIN_WIDTH) && ((width % group) == 0);
   endfunction

   // Returns {PG, GG} over the low n bits of p/g. Upper bits are ignored so
   // narrower groups are passed zero-extended.
   function automatic logic [1:0] group_pg_gg(input logic [MAX_GROUP-1:0] p,
                                              input logic [MAX_GROUP-1:0] g,
                                              input int n);
      logic pg;
      logic gg;
      pg = 1'b1;
      gg = 1'b0;
      for (int i = 0; i < MAX_GROUP; i++) begin
         if (i < n) begin
            gg = g[i] | (p[i] & gg);
            pg = pg & p[i];
         end
      end
      return {pg, gg};
   endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bus of cla_addsub_pipe.
//   in_valid/in_ready   : operand handshake (op, a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf, zero, neg)
//   master : operand producer / result consumer
//   slave  : the adder/subtractor
interface cla_addsub_pipe_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) ();

   logic             in_valid;
   logic             in_ready;
   alu_op_e          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, op, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero, neg
   );

   modport slave (
      input  in_valid, op, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero, neg
   );

endinterface

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block.
//   p, g : per-bit propagate/generate
//   ci   : carry into bit 0 of the group
//   sum  : p ^ bit carry
//   pg   : group propagate (AND of p)
//   gg   : group generate
module cla_group
   import alu_pkg::*;
#(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] p,
   input  logic [GROUP-1:0] g,
   input  logic             ci,
   output logic [GROUP-1:0] sum,
   output logic             pg,
   output logic             gg
);

   logic [GROUP-1:0] carry;

   // Every bit carry is a flat sum of products from ci and the lower g/p
   // bits, so no carry ripples through another bit of the group.
   always_comb begin
      logic acc;
      logic term;
      carry = '0;
      acc   = 1'b0;
      term  = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         term = ci;
         for (int k = 0; k < j; k++) begin
            term = term & p[k];
         end
         acc = term;
         for (int i = 0; i < j; i++) begin
            term = g[i];
            for (int k = i + 1; k < j; k++) begin
               term = term & p[k];
            end
            acc = acc | term;
         end
         carry[j] = acc;
      end
   end

   assign sum = p ^ carry;
   assign {pg, gg} = group_pg_gg(MAX_GROUP'(p), MAX_GROUP'(g), GROUP);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with ALU flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand/result handshake (slave side), see cla_addsub_pipe_if
// Operations: ADD a+b, SUB a-b, ADC a+b+cin, SBC a+~b+cin. cout is the carry
// out of the MSB (1 = no borrow for SUB/SBC), ovf is signed overflow.
// The pipeline advances only when the output register is empty or being
// drained; otherwise every stage holds.
module cla_addsub_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input logic              clk,
   input logic              rst_n,
   cla_addsub_pipe_if.slave bus
);

   localparam int NG = WIDTH / GROUP;

   if (!params_legal(WIDTH, GROUP)) begin : g_param_check
      $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and >= 4; GROUP must be 2, 4 or 8");
   end

   logic             en;

   logic [WIDTH-1:0] bx_c;
   logic             c0_c;
   logic [WIDTH-1:0] p_c;
   logic [WIDTH-1:0] g_c;
   logic [NG-1:0]    pg_c;
   logic [NG-1:0]    gg_c;

   logic             vld_p1;
   logic [WIDTH-1:0] p_p1;
   logic [WIDTH-1:0] g_p1;
   logic             c0_p1;
   logic [NG-1:0]    pg_p1;
   logic [NG-1:0]    gg_p1;

   logic [NG:0]      c_grp;
   logic [WIDTH-1:0] sum_c;
   logic             cmsb_c;
   // Each cla_group also reports its own PG/GG; the carry chain uses the
   // registered copies so it starts directly from flops.
   logic [NG-1:0]    unused_grp_pg;
   logic [NG-1:0]    unused_grp_gg;

   logic             vld_p2;
   logic [WIDTH-1:0] sum_p2;
   logic             cout_p2;
   logic             ovf_p2;
   logic             zero_p2;
   logic             neg_p2;

   assign en           = !vld_p2 || bus.out_ready;
   assign bus.in_ready = en;

   // ---- Operand prep (combinational, ahead of stage 1) ----
   always_comb begin
      bx_c = bus.b;
      c0_c = 1'b0;
      case (bus.op)
         OP_ADD: begin bx_c = bus.b;  c0_c = 1'b0;    end
         OP_SUB: begin bx_c = ~bus.b; c0_c = 1'b1;    end
         OP_ADC: begin bx_c = bus.b;  c0_c = bus.cin; end
         OP_SBC: begin bx_c = ~bus.b; c0_c = bus.cin; end
      endcase
   end

   assign p_c = bus.a ^ bx_c;
   assign g_c = bus.a & bx_c;

   for (genvar k = 0; k < NG; k++) begin : g_s1_grp
      assign {pg_c[k], gg_c[k]} = group_pg_gg(MAX_GROUP'(p_c[k*GROUP +: GROUP]),
                                              MAX_GROUP'(g_c[k*GROUP +: GROUP]),
                                              GROUP);
   end

   // ---- Stage 1 register: per-bit and per-group propagate/generate ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else if (en) begin
         vld_p1 <= bus.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (en && bus.in_valid) begin
         p_p1  <= p_c;
         g_p1  <= g_c;
         c0_p1 <= c0_c;
         pg_p1 <= pg_c;
         gg_p1 <= gg_c;
      end
   end

   // ---- Stage 2 logic: group carry chain and in-group sums ----
   always_comb begin
      c_grp    = '0;
      c_grp[0] = c0_p1;
      for (int k = 0; k < NG; k++) begin
         c_grp[k+1] = gg_p1[k] | (pg_p1[k] & c_grp[k]);
      end
   end

   for (genvar k = 0; k < NG; k++) begin : g_s2_grp
      cla_group #(
         .GROUP(GROUP)
      ) u_grp (
         .p   (p_p1[k*GROUP +: GROUP]),
         .g   (g_p1[k*GROUP +: GROUP]),
         .ci  (c_grp[k]),
         .sum (sum_c[k*GROUP +: GROUP]),
         .pg  (unused_grp_pg[k]),
         .gg  (unused_grp_gg[k])
      );
   end

   // Carry into the MSB recovered from its sum bit: sum = p ^ carry.
   assign cmsb_c = p_p1[WIDTH-1] ^ sum_c[WIDTH-1];

   // ---- Stage 2 register: result and flags ----
   // Only loaded by a valid op, so outputs hold their last value otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2  <= 1'b0;
         sum_p2  <= '0;
         cout_p2 <= 1'b0;
         ovf_p2  <= 1'b0;
         zero_p2 <= 1'b0;
         neg_p2  <= 1'b0;
      end else if (en) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            sum_p2  <= sum_c;
            cout_p2 <= c_grp[NG];
            ovf_p2  <= cmsb_c ^ c_grp[NG];
            zero_p2 <= (sum_c == '0);
            neg_p2  <= sum_c[WIDTH-1];
         end
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.sum       = sum_p2;
   assign bus.cout      = cout_p2;
   assign bus.ovf       = ovf_p2;
   assign bus.zero      = zero_p2;
   assign bus.neg       = neg_p2;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Testbench for cla_addsub_pipe: directed vectors on a 16/4 instance, an
// 8-bit directed case, and randomized handshake runs on 8/4 and 32/8
// instances checked against an arithmetic reference model.
module tb_cla_addsub_pipe;
   import alu_pkg::*;

   localparam int NOPS   = 10000;
   localparam int BUDGET = 60000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cla_addsub_pipe_if #(.WIDTH(16)) bus16 ();
   cla_addsub_pipe_if #(.WIDTH(8))  bus8  ();
   cla_addsub_pipe_if #(.WIDTH(32)) bus32 ();

   cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   cla_addsub_pipe #(.WIDTH(8),  .GROUP(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   cla_addsub_pipe #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   typedef struct {
      logic [63:0] sum;
      logic [3:0]  flg;   // {cout, ovf, zero, neg}
   } exp_t;

   function automatic exp_t model(input alu_op_e op, input logic [63:0] a,
                                  input logic [63:0] b, input logic cin, input int w);
      exp_t        m;
      logic [63:0] mask;
      logic [63:0] am;
      logic [63:0] bx;
      logic [63:0] full;
      logic        c0;
      mask = (64'd1 << w) - 64'd1;
      am   = a & mask;
      bx   = ((op == OP_SUB) || (op == OP_SBC)) ? (~b & mask) : (b & mask);
      c0   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
      full = am + bx + {63'd0, c0};
      m.sum = full & mask;
      m.flg = {full[w],
               (am[w-1] == bx[w-1]) && (m.sum[w-1] != am[w-1]),
               (m.sum == 64'd0),
               m.sum[w-1]};
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.op = OP_ADD;
      bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
      bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1; bus8.op  = OP_ADD;
      bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.op = OP_ADD;
      bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
   endtask

   task automatic test_reset();
      idle_all();
      #1;
      total++;
      if ({bus16.out_valid, bus16.cout, bus16.ovf, bus16.zero, bus16.neg} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 00000", {bus16.out_valid, bus16.cout, bus16.ovf, bus16.zero, bus16.neg});
      end
      total++;
      if (bus16.sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", bus16.sum); end
      total++;
      if (bus16.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus16.in_ready); end
      repeat (2) step();
      rst_n = 1'b1;
      step();
      // Two ops in flight, then reset.
      bus16.in_valid = 1'b1; bus16.op = OP_ADD; bus16.a = 16'h1234; bus16.b = 16'h1111;
      step();
      bus16.a = 16'h0F0F; bus16.b = 16'h0101;
      step();
      bus16.in_valid = 1'b0;
      total++;
      if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'h2345) begin
         bad++;
         $display("FAIL inflight_result: got v=%b sum=%h want v=1 sum=2345", bus16.out_valid, bus16.sum);
      end
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({bus16.out_valid, bus16.cout, bus16.ovf, bus16.zero, bus16.neg} !== 5'b0 ||
             bus16.sum !== 16'h0000 || bus16.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_%0d: got v=%b sum=%h flags=%b rdy=%b want v=0 sum=0000 flags=0000 rdy=1",
                     i, bus16.out_valid, bus16.sum, {bus16.cout, bus16.ovf, bus16.zero, bus16.neg}, bus16.in_ready);
         end
         if (i < 3) step();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (bus16.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_release_%0d: got out_valid=%b want 0", i, bus16.out_valid);
         end
      end
   endtask

   task automatic test_arith();
      alu_op_e     t_op  [9] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_ADC, OP_SBC, OP_ADC, OP_SBC};
      logic [15:0] t_a   [9] = '{16'h7FFF, 16'h8000, 16'h0005, 16'h0000, 16'h8000, 16'hFFFF, 16'h0010, 16'h1234, 16'h0010};
      logic [15:0] t_b   [9] = '{16'h0001, 16'h8000, 16'h0005, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h4321, 16'h0001};
      logic        t_cin [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [15:0] t_sum [9] = '{16'h8000, 16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h000E, 16'h5555, 16'h000F};
      logic [3:0]  t_flg [9] = '{4'b0101, 4'b1110, 4'b1010, 4'b0001, 4'b1100, 4'b1010, 4'b1000, 4'b0000, 4'b1000};
      for (int i = 0; i < 9; i++) begin
         bus16.in_valid = 1'b1; bus16.op = t_op[i];
         bus16.a = t_a[i]; bus16.b = t_b[i]; bus16.cin = t_cin[i];
         total++;
         if (bus16.in_ready !== 1'b1) begin bad++; $display("FAIL arith%0d_in_ready: got %b want 1", i, bus16.in_ready); end
         step();
         bus16.in_valid = 1'b0;
         total++;
         if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL arith%0d_early: got out_valid=%b want 0", i, bus16.out_valid); end
         step();
         total++;
         if (bus16.out_valid !== 1'b1) begin bad++; $display("FAIL arith%0d_valid: got %b want 1", i, bus16.out_valid); end
         total++;
         if (bus16.sum !== t_sum[i]) begin bad++; $display("FAIL arith%0d_sum: got %h want %h", i, bus16.sum, t_sum[i]); end
         total++;
         if ({bus16.cout, bus16.ovf, bus16.zero, bus16.neg} !== t_flg[i]) begin
            bad++;
            $display("FAIL arith%0d_flags(c,v,z,n): got %b want %b", i, {bus16.cout, bus16.ovf, bus16.zero, bus16.neg}, t_flg[i]);
         end
         step();
         total++;
         if (bus16.out_valid !== 1'b0 || bus16.sum !== t_sum[i]) begin
            bad++;
            $display("FAIL arith%0d_hold: got v=%b sum=%h want v=0 sum=%h", i, bus16.out_valid, bus16.sum, t_sum[i]);
         end
      end
   endtask

   task automatic test_sub8();
      bus8.in_valid = 1'b1; bus8.op = OP_SUB; bus8.a = 8'h80; bus8.b = 8'h01; bus8.cin = 1'b0;
      step();
      bus8.in_valid = 1'b0;
      step();
      total++;
      if (bus8.out_valid !== 1'b1 || bus8.sum !== 8'h7F) begin
         bad++;
         $display("FAIL sub8_sum: got v=%b sum=%h want v=1 sum=7f", bus8.out_valid, bus8.sum);
      end
      total++;
      if ({bus8.cout, bus8.ovf, bus8.zero, bus8.neg} !== 4'b1100) begin
         bad++;
         $display("FAIL sub8_flags(c,v,z,n): got %b want 1100", {bus8.cout, bus8.ovf, bus8.zero, bus8.neg});
      end
      step();
   endtask

   task automatic test_backpressure();
      bus16.out_ready = 1'b0;
      bus16.in_valid  = 1'b1; bus16.op = OP_ADD; bus16.cin = 1'b0;
      bus16.a = 16'd1; bus16.b = 16'd1;
      step();
      bus16.a = 16'd2; bus16.b = 16'd2;
      step();
      bus16.a = 16'd3; bus16.b = 16'd3;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'd2 || bus16.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_%0d: got v=%b sum=%h rdy=%b want v=1 sum=0002 rdy=0",
                     i, bus16.out_valid, bus16.sum, bus16.in_ready);
         end
         if (i < 4) step();
      end
      bus16.out_ready = 1'b1;
      #1;
      total++;
      if (bus16.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", bus16.in_ready); end
      step();
      total++;
      if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'd4) begin
         bad++; $display("FAIL drain_4: got v=%b sum=%h want v=1 sum=0004", bus16.out_valid, bus16.sum);
      end
      bus16.a = 16'd4; bus16.b = 16'd4;
      step();
      total++;
      if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'd6) begin
         bad++; $display("FAIL drain_6: got v=%b sum=%h want v=1 sum=0006", bus16.out_valid, bus16.sum);
      end
      bus16.in_valid = 1'b0;
      step();
      total++;
      if (bus16.out_valid !== 1'b1 || bus16.sum !== 16'd8) begin
         bad++; $display("FAIL drain_8: got v=%b sum=%h want v=1 sum=0008", bus16.out_valid, bus16.sum);
      end
      step();
      total++;
      if (bus16.out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got out_valid=%b want 0", bus16.out_valid); end
   endtask

   task automatic test_sweep();
      fork
         begin : sweep8
            exp_t      q8[$];
            exp_t      e8;
            int        sent8 = 0;
            int        cyc8  = 0;
            alu_op_e   op8   = alu_op_e'($urandom_range(0, 3));
            logic [7:0] a8   = 8'($urandom);
            logic [7:0] b8   = 8'($urandom);
            logic      c8    = 1'($urandom);
            logic      inf8;
            logic      outf8;
            while ((sent8 < NOPS || q8.size() != 0) && cyc8 < BUDGET) begin
               bus8.out_ready = ($urandom_range(0, 3) != 0);
               bus8.in_valid  = (sent8 < NOPS) && ($urandom_range(0, 3) != 0);
               bus8.op = op8; bus8.a = a8; bus8.b = b8; bus8.cin = c8;
               #1;
               outf8 = bus8.out_valid && bus8.out_ready;
               inf8  = bus8.in_valid && bus8.in_ready;
               if (outf8) begin
                  total++;
                  if (q8.size() == 0) begin
                     bad++; $display("FAIL sweep8_extra: got unexpected result %h want none", bus8.sum);
                  end else begin
                     e8 = q8.pop_front();
                     if ({56'd0, bus8.sum} !== e8.sum || {bus8.cout, bus8.ovf, bus8.zero, bus8.neg} !== e8.flg) begin
                        bad++;
                        $display("FAIL sweep8: got sum=%h flags=%b want sum=%h flags=%b",
                                 bus8.sum, {bus8.cout, bus8.ovf, bus8.zero, bus8.neg}, e8.sum[7:0], e8.flg);
                     end
                  end
               end
               if (inf8) begin
                  q8.push_back(model(op8, {56'd0, a8}, {56'd0, b8}, c8, 8));
                  sent8++;
                  op8 = alu_op_e'($urandom_range(0, 3));
                  a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
               end
               @(posedge clk);
               #1;
               cyc8++;
            end
            total++;
            if (cyc8 >= BUDGET) begin
               bad++; $display("FAIL sweep8_timeout: got %0d ops sent, %0d pending want all done", sent8, q8.size());
            end
            bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
         end
         begin : sweep32
            exp_t       q32[$];
            exp_t       e32;
            int         sent32 = 0;
            int         cyc32  = 0;
            alu_op_e    op32   = alu_op_e'($urandom_range(0, 3));
            logic [31:0] a32   = $urandom;
            logic [31:0] b32   = $urandom;
            logic       c32    = 1'($urandom);
            logic       inf32;
            logic       outf32;
            while ((sent32 < NOPS || q32.size() != 0) && cyc32 < BUDGET) begin
               bus32.out_ready = ($urandom_range(0, 3) != 0);
               bus32.in_valid  = (sent32 < NOPS) && ($urandom_range(0, 3) != 0);
               bus32.op = op32; bus32.a = a32; bus32.b = b32; bus32.cin = c32;
               #1;
               outf32 = bus32.out_valid && bus32.out_ready;
               inf32  = bus32.in_valid && bus32.in_ready;
               if (outf32) begin
                  total++;
                  if (q32.size() == 0) begin
                     bad++; $display("FAIL sweep32_extra: got unexpected result %h want none", bus32.sum);
                  end else begin
                     e32 = q32.pop_front();
                     if ({32'd0, bus32.sum} !== e32.sum || {bus32.cout, bus32.ovf, bus32.zero, bus32.neg} !== e32.flg) begin
                        bad++;
                        $display("FAIL sweep32: got sum=%h flags=%b want sum=%h flags=%b",
                                 bus32.sum, {bus32.cout, bus32.ovf, bus32.zero, bus32.neg}, e32.sum[31:0], e32.flg);
                     end
                  end
               end
               if (inf32) begin
                  q32.push_back(model(op32, {32'd0, a32}, {32'd0, b32}, c32, 32));
                  sent32++;
                  op32 = alu_op_e'($urandom_range(0, 3));
                  a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
               end
               @(posedge clk);
               #1;
               cyc32++;
            end
            total++;
            if (cyc32 >= BUDGET) begin
               bad++; $display("FAIL sweep32_timeout: got %0d ops sent, %0d pending want all done", sent32, q32.size());
            end
            bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
         end
      join
   endtask

   initial begin
      test_reset();
      test_arith();
      test_sub8();
      test_backpressure();
      idle_all();
      step();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
